// File: rtl/disp_buf_arbiter_pkg.sv
// Shared definitions for the two-requester display character buffer:
// FSM encoding, row geometry, fill character and address helpers.
package disp_buf_arbiter_pkg;

  localparam int ADDR_W = 5;
  localparam int COL_W  = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int          DISP_ROW_LEN = 16;
  localparam logic [7:0]  DISP_BLANK   = 8'h20;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] char_t;

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_GRANT  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  function automatic addr_t make_addr(input logic row, input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/disp_buf_arbiter_if.sv
// Requester and LCD-read bundle for disp_buf_arbiter. The master side is the
// requesters plus the LCD reader; the slave side is the arbiter itself.
interface disp_buf_arbiter_if;
  import disp_buf_arbiter_pkg::*;

  // Handshake: a character transfers on a rising edge where gnt_x (acting as
  // ready) and wvalid_x are both high; wvalid_x/wdata_x are ignored otherwise.
  // req_x must stay high for the whole row; dropping it aborts the burst.
  addr_t mem_addr;
  char_t mem_bus;
  logic  req_a, req_b;
  logic  row_a, row_b;
  logic  wvalid_a, wvalid_b;
  char_t wdata_a, wdata_b;
  logic  gnt_a, gnt_b;
  logic  done_a, done_b;
  logic  busy;

  modport master (
    output mem_addr, req_a, req_b, row_a, row_b,
           wvalid_a, wvalid_b, wdata_a, wdata_b,
    input  mem_bus, gnt_a, gnt_b, done_a, done_b, busy
  );

  modport slave (
    input  mem_addr, req_a, req_b, row_a, row_b,
           wvalid_a, wvalid_b, wdata_a, wdata_b,
    output mem_bus, gnt_a, gnt_b, done_a, done_b, busy
  );

endinterface

// File: rtl/char_ram.sv
// 32x8 character store: one write port, one registered read port.
// Only the read register is reset; the array is initialised by the clear sweep.
module char_ram
  import disp_buf_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  addr_t waddr,
  input  char_t wdata,
  input  addr_t raddr,
  output char_t rdata
);

  char_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-during-write to the same address returns the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/disp_buf_arbiter.sv
// Round-robin arbiter giving two requesters whole-row write access to a
// 2x16 LCD character buffer, with a 32-cycle blank-fill after reset.
module disp_buf_arbiter
  import disp_buf_arbiter_pkg::*;
#(
  parameter int         ROW_LEN = DISP_ROW_LEN,
  parameter logic [7:0] BLANK   = DISP_BLANK
) (
  input  logic               clk,
  input  logic               rst,
  disp_buf_arbiter_if.slave  bus,
  output state_t             state_dbg
);

  state_t            state;
  addr_t             clr_addr;
  logic [COL_W-1:0]  col;
  logic              row_q;
  logic              owner_b;
  logic              last_b;
  logic              gnt_a_q, gnt_b_q;
  logic              done_a_q, done_b_q;
  logic              busy_q;

  logic  own_req, own_wvalid, wr_fire, last_col, pick_b;
  char_t own_wdata;
  logic  ram_we;
  addr_t ram_waddr;
  char_t ram_wdata;

  assign own_req    = owner_b ? bus.req_b    : bus.req_a;
  assign own_wvalid = owner_b ? bus.wvalid_b : bus.wvalid_a;
  assign own_wdata  = owner_b ? bus.wdata_b  : bus.wdata_a;
  assign wr_fire    = (state == S_GRANT) && own_wvalid;
  // ROW_LEN above 16 is not supported: the column counter is COL_W bits.
  assign last_col   = (col == COL_W'(ROW_LEN - 1));
  // B wins when it asks alone, or when both ask and A held the last grant.
  assign pick_b     = bus.req_b && (!bus.req_a || !last_b);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (!rst) begin
      if (state == S_CLEAR) begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr;
        ram_wdata = BLANK;
      end else if (wr_fire) begin
        ram_we    = 1'b1;
        ram_waddr = make_addr(row_q, col);
        ram_wdata = own_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
      col      <= '0;
      row_q    <= 1'b0;
      owner_b  <= 1'b0;
      last_b   <= 1'b1;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == addr_t'(DEPTH - 1)) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        S_IDLE: begin
          if (bus.req_a || bus.req_b) begin
            owner_b <= pick_b;
            row_q   <= pick_b ? bus.row_b : bus.row_a;
            col     <= '0;
            gnt_a_q <= !pick_b;
            gnt_b_q <= pick_b;
            busy_q  <= 1'b1;
            state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (wr_fire && !last_col) begin
            col <= col + 1'b1;
          end
          // A completed row wins over a simultaneous req drop.
          if ((wr_fire && last_col) || !own_req) begin
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            busy_q   <= 1'b0;
            last_b   <= owner_b;
            done_a_q <= wr_fire && last_col && !owner_b;
            done_b_q <= wr_fire && last_col && owner_b;
            state    <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_CLEAR;
      endcase
    end
  end

  char_ram u_char_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (bus.mem_addr),
    .rdata (bus.mem_bus)
  );

  assign bus.gnt_a  = gnt_a_q;
  assign bus.gnt_b  = gnt_b_q;
  assign bus.done_a = done_a_q;
  assign bus.done_b = done_b_q;
  assign bus.busy   = busy_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_disp_buf_arbiter.sv
// Bench for disp_buf_arbiter: table of row bursts, hand-written contest and
// reset sequences, and random bursts checked against a shadow buffer model.
module tb_disp_buf_arbiter;
  import disp_buf_arbiter_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t state_dbg;

  disp_buf_arbiter_if bif ();

  disp_buf_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model_mem [32];
  bit         model_last_b;
  logic [7:0] exp_q [$];

  typedef struct {
    bit          who_b;
    bit          both;
    bit          row;
    logic [127:0] text;
    int          n_chars;
    bit          gated;
    bit          exp_win_b;
    int          exp_cyc;
    int          exp_done;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ch(input logic [127:0] t, input int k);
    return t[127 - 8*k -: 8];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bif.req_a    = 1'b0;
    bif.req_b    = 1'b0;
    bif.row_a    = 1'b0;
    bif.row_b    = 1'b0;
    bif.wvalid_a = 1'b0;
    bif.wvalid_b = 1'b0;
    bif.wdata_a  = '0;
    bif.wdata_b  = '0;
  endtask

  // Counts cycles from reset release until busy falls, then resets the model.
  task automatic count_clear(input string tag);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bif.busy && cyc < 100);
    check($sformatf("%s busy fall cycles", tag), cyc, 32);
    for (int a = 0; a < 32; a++) model_mem[a] = DISP_BLANK;
    model_last_b = 1'b1;
  endtask

  task automatic reset_and_clear(input string tag);
    rst = 1'b1;
    tick();
    tick();
    check($sformatf("%s rst gnt_a", tag), bif.gnt_a, 0);
    check($sformatf("%s rst gnt_b", tag), bif.gnt_b, 0);
    check($sformatf("%s rst done", tag), {bif.done_a, bif.done_b}, 0);
    check($sformatf("%s rst busy", tag), bif.busy, 1);
    check($sformatf("%s rst mem_bus", tag), bif.mem_bus, 0);
    check($sformatf("%s rst state", tag), state_dbg, S_CLEAR);
    rst = 1'b0;
    count_clear(tag);
  endtask

  task automatic verify_mem(input string tag);
    logic [7:0] exp;
    for (int a = 0; a < 32; a++) exp_q.push_back(model_mem[a]);
    for (int a = 0; a < 32; a++) begin
      bif.mem_addr = 5'(a);
      tick();
      exp = exp_q.pop_front();
      check($sformatf("%s mem[%0d]", tag, a), bif.mem_bus, exp);
    end
  endtask

  // Drives one row burst; n_chars < 16 means the owner drops req after that
  // many characters. The non-owner's write lines carry random junk.
  task automatic run_burst(input string tag, input bit who_b, input bit both,
                           input bit row, input logic [127:0] text,
                           input int n_chars, input bit gated, input bit exp_win_b,
                           input int exp_cyc, input int exp_done);
    int  k, cyc, dones, wait_n;
    bit  seen, ended, win_b, mutex_bad, busy_bad, v, own_gnt, own_done;
    bif.row_a = row;
    bif.row_b = row;
    bif.req_a = !who_b || both;
    bif.req_b = who_b || both;
    seen = 0;
    wait_n = 0;
    while (!seen && wait_n < 8) begin
      tick();
      wait_n++;
      if (bif.gnt_a || bif.gnt_b) seen = 1;
    end
    check($sformatf("%s grant seen", tag), seen, 1);
    if (seen) begin
      win_b = bif.gnt_b;
      check($sformatf("%s winner_b", tag), win_b, exp_win_b);
      if (both) begin
        if (win_b) bif.req_a = 1'b0;
        else       bif.req_b = 1'b0;
      end
      k = 0; cyc = 0; dones = 0; ended = 0; mutex_bad = 0; busy_bad = 0;
      while (!ended && cyc < 80) begin
        if (bif.gnt_a && bif.gnt_b) mutex_bad = 1;
        own_gnt  = win_b ? bif.gnt_b  : bif.gnt_a;
        own_done = win_b ? bif.done_b : bif.done_a;
        if (own_done) dones++;
        if (own_gnt) begin
          if (!bif.busy) busy_bad = 1;
          v = 0;
          if (k == n_chars && n_chars < 16) begin
            if (win_b) bif.req_b = 1'b0;
            else       bif.req_a = 1'b0;
          end else begin
            v = (!gated || (cyc % 2 == 1)) && k < 16;
          end
          cyc++;
          if (win_b) begin
            bif.wvalid_b = v;
            bif.wdata_b  = v ? ch(text, k) : 8'($urandom);
            bif.wvalid_a = 1'($urandom_range(0, 1));
            bif.wdata_a  = 8'($urandom);
          end else begin
            bif.wvalid_a = v;
            bif.wdata_a  = v ? ch(text, k) : 8'($urandom);
            bif.wvalid_b = 1'($urandom_range(0, 1));
            bif.wdata_b  = 8'($urandom);
          end
          if (v) begin
            model_mem[{row, 4'(k)}] = ch(text, k);
            k++;
          end
        end else begin
          ended = 1;
          idle_inputs();
        end
        tick();
      end
      own_done = win_b ? bif.done_b : bif.done_a;
      if (own_done) dones++;
      check($sformatf("%s burst ended", tag), ended, 1);
      check($sformatf("%s gnt cycles", tag), cyc, exp_cyc);
      check($sformatf("%s done pulses", tag), dones, exp_done);
      check($sformatf("%s gnt mutex", tag), mutex_bad, 0);
      check($sformatf("%s busy in grant", tag), busy_bad, 0);
    end
    idle_inputs();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] txt;
    bit b_both, b_who, b_row, b_gated, b_win;
    int n;

    rst = 1'b1;
    idle_inputs();
    bif.mem_addr = '0;

    vecs[0] = '{1'b0, 1'b0, 1'b1, "VOTES CAST: 0042", 16, 1'b0, 1'b0, 16, 1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, "HELLO, WORLD 123", 16, 1'b1, 1'b1, 32, 1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, "ABCDEFGHIJKLMNOP",  5, 1'b0, 1'b0,  6, 0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, "0123456789ABCDEF", 16, 1'b0, 1'b1, 16, 1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, "abcdefghijklmnop",  3, 1'b1, 1'b0,  7, 0};

    reset_and_clear("init");
    verify_mem("after clear");

    // Two simultaneous contests around one B-only grant: A, B, then A again.
    bif.req_a = 1'b1; bif.req_b = 1'b1;
    tick();
    check("contest1 gnt_a", bif.gnt_a, 1);
    check("contest1 gnt_b", bif.gnt_b, 0);
    bif.req_a = 1'b0;
    tick();
    check("contest1 abort gnt_a", bif.gnt_a, 0);
    check("contest1 abort done_a", bif.done_a, 0);
    tick();
    tick();
    check("contest1 then gnt_b", bif.gnt_b, 1);
    check("contest1 then gnt_a", bif.gnt_a, 0);
    bif.req_b = 1'b0;
    tick();
    bif.req_a = 1'b1; bif.req_b = 1'b1;
    tick();
    tick();
    check("contest2 gnt_a", bif.gnt_a, 1);
    check("contest2 gnt_b", bif.gnt_b, 0);
    idle_inputs();
    tick();
    tick();
    model_last_b = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_burst($sformatf("vec%0d", i), vecs[i].who_b, vecs[i].both, vecs[i].row,
                vecs[i].text, vecs[i].n_chars, vecs[i].gated, vecs[i].exp_win_b,
                vecs[i].exp_cyc, vecs[i].exp_done);
      model_last_b = vecs[i].exp_win_b;
      verify_mem($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      b_both  = 1'($urandom_range(0, 1));
      b_who   = 1'($urandom_range(0, 1));
      b_row   = 1'($urandom_range(0, 1));
      b_gated = 1'($urandom_range(0, 1));
      txt     = {$urandom, $urandom, $urandom, $urandom};
      n       = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 16;
      b_win   = b_both ? !model_last_b : b_who;
      run_burst($sformatf("rnd%0d", i), b_who, b_both, b_row, txt, n, b_gated, b_win,
                (n == 16) ? (b_gated ? 32 : 16) : (b_gated ? 2*n + 1 : n + 1),
                (n == 16) ? 1 : 0);
      model_last_b = b_win;
      verify_mem($sformatf("rnd%0d", i));
    end

    // Reset landing on the 8th character of a burst restarts the clear.
    txt = "MIDBURST RESET!!";
    bif.req_a = 1'b1;
    bif.row_a = 1'b0;
    n = 0;
    while (!bif.gnt_a && n < 8) begin
      tick();
      n++;
    end
    check("midrst grant seen", bif.gnt_a, 1);
    for (int k = 0; k < 7; k++) begin
      bif.wvalid_a = 1'b1;
      bif.wdata_a  = ch(txt, k);
      tick();
    end
    bif.wvalid_a = 1'b1;
    bif.wdata_a  = ch(txt, 7);
    rst = 1'b1;
    tick();
    check("midrst gnt_a", bif.gnt_a, 0);
    check("midrst busy", bif.busy, 1);
    check("midrst done_a", bif.done_a, 0);
    check("midrst state", state_dbg, S_CLEAR);
    rst = 1'b0;
    idle_inputs();
    count_clear("midrst");
    verify_mem("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
